// File: rtl/onehot_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : onehot_req_arbiter_if
// Description : Request/grant bundle between the arbiter and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface onehot_req_arbiter_if #(
    parameter int DROP_W = 8
);
    logic [3:0]        req_in;
    logic              ready;
    logic [3:0]        onehot_out;
    logic              valid;
    logic [3:0]        pending;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output req_in,
        output ready,
        input  onehot_out,
        input  valid,
        input  pending,
        input  drop_cnt
    );

    modport slave (
        input  req_in,
        input  ready,
        output onehot_out,
        output valid,
        output pending,
        output drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/onehot_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onehot_req_arbiter
// Description : Synchronises four request strobes, latches their rising edges
//               and hands them out one at a time as a round-robin one-hot word.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_req_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int DROP_W      = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    onehot_req_arbiter_if.slave   bus
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  r_hist;
    logic [3:0]                  r_pending;
    logic [3:0]                  r_onehot;
    logic                        r_valid;
    logic [DROP_W-1:0]           r_drop_cnt;
    logic [1:0]                  r_ptr;
    logic [1:0]                  r_idx;
    logic [0:0]                  r_state;

    logic [3:0] w_s;
    logic [3:0] w_rise;
    logic       w_hs;
    logic [3:0] w_hs_bits;
    logic [3:0] w_drop_bits;
    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_pick_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 4'b0000;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_in};
            r_hist <= w_s;
        end
    end

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_s & ~r_hist;
    assign w_hs        = (r_state == S_PRESENT) && bus.ready;
    assign w_hs_bits   = w_hs ? r_onehot : 4'b0000;
    assign w_drop_bits = w_rise & r_pending & ~w_hs_bits;

    // Rotate pending so that bit 0 of w_rot is the bit at the pointer; the
    // first set bit of w_rot is then the round-robin winner's offset.
    assign w_dbl = {r_pending, r_pending};
    assign w_rot = w_dbl[{1'b0, r_ptr} +: 4];

    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign w_pick_idx = r_ptr + w_off;

    // A fresh edge on a bit whose handshake completes this cycle is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= 4'b0000;
            r_drop_cnt <= '0;
        end else begin
            r_pending <= (r_pending & ~w_hs_bits) | w_rise;
            if ((|w_drop_bits) && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_idx    <= 2'd0;
            r_onehot <= 4'b0000;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending != 4'b0000) begin
                        r_idx    <= w_pick_idx;
                        r_onehot <= 4'b0001 << w_pick_idx;
                        r_valid  <= 1'b1;
                        r_state  <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (bus.ready) begin
                        r_ptr    <= r_idx + 2'd1;
                        r_onehot <= 4'b0000;
                        r_valid  <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_onehot <= 4'b0000;
                    r_valid  <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.onehot_out = r_onehot;
    assign bus.valid      = r_valid;
    assign bus.pending    = r_pending;
    assign bus.drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_req_arbiter
// Description : Directed and random checks of onehot_req_arbiter against a
//               cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_req_arbiter;

    localparam int SYNC_STAGES = 2;
    localparam int DROP_W      = 8;
    localparam int DROP_MAX    = (1 << DROP_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    onehot_req_arbiter_if #(.DROP_W(DROP_W)) bus ();

    onehot_req_arbiter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DROP_W      (DROP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: req_in samples since the last reset, plus the
    // architectural state as plain integers.
    logic [3:0] samples[$];
    logic [3:0] m_pend;
    bit         m_valid;
    int         m_idx;
    int         m_ptr;
    int         m_drop;
    logic [3:0] dut_grants[$];

    function automatic logic [3:0] smp(input int i);
        if (i < 0 || i >= samples.size()) return 4'b0000;
        return samples[i];
    endfunction

    task automatic model_reset();
        samples.delete();
        m_pend  = 4'b0000;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        m_drop  = 0;
    endtask

    task automatic model_step(input logic [3:0] req, input bit rdy);
        int         n;
        logic [3:0] rise;
        logic [3:0] hsb;
        logic [3:0] old;
        n = samples.size();
        samples.push_back(req);
        // An edge sampled at clock n reaches the arbiter SYNC_STAGES clocks later.
        rise = smp(n - SYNC_STAGES) & ~smp(n - SYNC_STAGES - 1);
        hsb  = (m_valid && rdy) ? 4'(1 << m_idx) : 4'b0000;
        if (((rise & m_pend & ~hsb) != 4'b0000) && m_drop < DROP_MAX) m_drop++;
        old    = m_pend;
        m_pend = (m_pend & ~hsb) | rise;
        if (m_valid) begin
            if (rdy) begin
                m_valid = 1'b0;
                m_ptr   = (m_idx + 1) % 4;
            end
        end else if (old != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (old[(m_ptr + k) % 4]) begin
                    m_idx = (m_ptr + k) % 4;
                    break;
                end
            end
            m_valid = 1'b1;
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(input logic [3:0] req, input bit rdy);
        bus.req_in = req;
        bus.ready  = rdy;
        if (bus.valid && rdy) dut_grants.push_back(bus.onehot_out);
        @(posedge clk);
        model_step(req, rdy);
        #1;
        chk("valid",    32'(bus.valid),      32'(m_valid));
        chk("onehot",   32'(bus.onehot_out), m_valid ? (32'd1 << m_idx) : 32'd0);
        chk("pending",  32'(bus.pending),    32'(m_pend));
        chk("drop_cnt", 32'(bus.drop_cnt),   32'(m_drop));
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] req);
        bus.req_in = req;
        rst = 1'b1;
        #1;
        chk("rst_valid",   32'(bus.valid),      32'd0);
        chk("rst_onehot",  32'(bus.onehot_out), 32'd0);
        chk("rst_pending", 32'(bus.pending),    32'd0);
        chk("rst_drop",    32'(bus.drop_cnt),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_valid(input logic [3:0] req, input bit rdy, input int budget);
        for (int i = 0; i < budget && !bus.valid; i++) cycle(req, rdy);
        chk("wait_valid", 32'(bus.valid), 32'd1);
    endtask

    logic [3:0] rq;

    initial begin
        bus.req_in = 4'b0000;
        bus.ready  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(4'b0000);

        // Single request: pending at E2, grant at E3, gone at E4, no regrant.
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0100, 1'b1);
            if (i == 2) chk("t1_pend_e2", 32'(bus.pending), 32'h4);
            if (i == 3) chk("t1_grant_e3", 32'({bus.valid, bus.onehot_out}), 32'h14);
            if (i == 4) chk("t1_clear_e4", 32'({bus.valid, bus.onehot_out, bus.pending}), 32'h0);
            if (i > 4)  chk("t1_no_regrant", 32'(bus.valid), 32'd0);
        end
        repeat (3) cycle(4'b0000, 1'b1);

        // All four at once: ascending order from pointer 0, no drops.
        do_reset(4'b0000);
        dut_grants.delete();
        repeat (16) cycle(4'b1111, 1'b1);
        chk("t2_ngrants", 32'(dut_grants.size()), 32'd4);
        if (dut_grants.size() == 4) begin
            chk("t2_g0", 32'(dut_grants[0]), 32'h1);
            chk("t2_g1", 32'(dut_grants[1]), 32'h2);
            chk("t2_g2", 32'(dut_grants[2]), 32'h4);
            chk("t2_g3", 32'(dut_grants[3]), 32'h8);
        end
        chk("t2_drop", 32'(bus.drop_cnt), 32'd0);
        repeat (3) cycle(4'b0000, 1'b1);

        // Round robin: after granting bit 1, bit 3 beats bit 0.
        do_reset(4'b0000);
        repeat (8) cycle(4'b0010, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);
        dut_grants.delete();
        cycle(4'b1001, 1'b1);
        repeat (10) cycle(4'b0000, 1'b1);
        chk("t3_ngrants", 32'(dut_grants.size()), 32'd2);
        if (dut_grants.size() == 2) begin
            chk("t3_first",  32'(dut_grants[0]), 32'h8);
            chk("t3_second", 32'(dut_grants[1]), 32'h1);
        end

        // Backpressure with three dropped re-pulses of bit 0.
        do_reset(4'b0000);
        cycle(4'b0001, 1'b0);
        wait_valid(4'b0000, 1'b0, 10);
        for (int i = 0; i < 10; i++) begin
            cycle((i % 3 == 0 && i < 9) ? 4'b0001 : 4'b0000, 1'b0);
            chk("t4_hold", 32'({bus.valid, bus.onehot_out}), 32'h11);
        end
        chk("t4_drop3", 32'(bus.drop_cnt), 32'd3);
        dut_grants.delete();
        repeat (8) cycle(4'b0000, 1'b1);
        chk("t4_once", 32'(dut_grants.size()), 32'd1);
        if (dut_grants.size() == 1) chk("t4_bit0", 32'(dut_grants[0]), 32'h1);

        // Edge on bit 2 coincident with its own handshake.
        do_reset(4'b0000);
        cycle(4'b0100, 1'b0);
        wait_valid(4'b0000, 1'b0, 10);
        cycle(4'b0000, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        chk("t5_kept",  32'(bus.pending[2]), 32'd1);
        chk("t5_nodrop", 32'(bus.drop_cnt),  32'd0);
        chk("t5_gap",   32'(bus.valid),      32'd0);
        cycle(4'b0000, 1'b0);
        chk("t5_regrant", 32'({bus.valid, bus.onehot_out}), 32'h14);
        repeat (4) cycle(4'b0000, 1'b1);

        // Reset in the middle of a stalled grant, request held through it.
        do_reset(4'b0000);
        wait_valid(4'b0010, 1'b0, 10);
        chk("t6_pre", 32'({bus.valid, bus.onehot_out}), 32'h12);
        do_reset(4'b0010);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0010, 1'b0);
            if (i == 2) chk("t6_pend_e2", 32'(bus.pending), 32'h2);
            if (i == 3) chk("t6_grant_e3", 32'({bus.valid, bus.onehot_out}), 32'h12);
        end
        repeat (4) cycle(4'b0000, 1'b1);

        // Saturation of the drop counter.
        do_reset(4'b0000);
        cycle(4'b0001, 1'b0);
        wait_valid(4'b0000, 1'b0, 10);
        for (int i = 0; i < 300; i++) begin
            cycle(4'b0001, 1'b0);
            cycle(4'b0000, 1'b0);
        end
        repeat (4) cycle(4'b0000, 1'b0);
        chk("t7_sat", 32'(bus.drop_cnt), 32'd255);
        repeat (4) cycle(4'b0000, 1'b1);

        // Random traffic with occasional resets.
        do_reset(4'b0000);
        rq = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            if ($urandom_range(0, 499) == 0) do_reset(rq);
            cycle(rq, $urandom_range(0, 2) != 0);
            chk("onehot_legal", 32'($countones(bus.onehot_out) <= 1), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_req_arbiter.md
Name: onehot_req_arbiter

Overview:
Upstream feeder for the team's 4-to-2 encoder stage. Four asynchronous request lines (buttons or external strobes) pass through a synchronizer and a rising-edge detector, then latch as pending requests. A round-robin state machine presents them one at a time as a clean one-hot word with a valid/ready handshake. The downstream encoder therefore sees only 0000 or exactly one active bit. The multi-bit input case is structurally impossible.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each per-bit synchronizer chain (legal values 2..4).
DROP_W, 8, width of the saturating dropped-request counter.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_in  input  4  asynchronous request levels; a request is a 0->1 transition.
ready  input  1  downstream accepts the current onehot_out when high with valid high.
onehot_out  output  4  granted request, one-hot; 4'b0000 whenever valid=0.
valid  output  1  onehot_out holds a grant.
pending  output  4  latched, not-yet-granted requests (includes the bit currently presented).
drop_cnt  output  DROP_W  count of request edges lost because that bit was already pending; saturates at all-ones.

Behaviour:
- Reset (async assert, sync-style release on the next clk edge). All of the following clear to 0: synchronizer flops, edge-history flops, pending, onehot_out, valid, drop_cnt. Round-robin pointer ptr goes to 0. State goes to IDLE.
- Reset mid-operation: an in-flight grant is discarded with no handshake. A req_in still held high after reset release counts as a new rising edge, because the history flop is 0.
- Synchronizer: req_in[i] passes through SYNC_STAGES flops, giving s[i]. h[i] is s[i] delayed by one clock. rise[i] = s[i] & ~h[i].
- Latency with SYNC_STAGES=2:
  - req_in rises before edge E0.
  - pending[i] sets at E2.
  - valid/onehot_out assert at E3 (IDLE, no contention).
  - In general, SYNC_STAGES+1 edges to valid.
- Pending update per bit, each clock:
  - set if rise[i];
  - clear if a handshake completes on bit i this cycle;
  - set wins over clear, so a new edge coincident with the handshake of the same bit is kept as a fresh request.
- rise[i] while pending[i]=1 and no handshake on bit i: the edge is dropped, and drop_cnt increments by 1, saturating. If several bits drop in the same cycle, drop_cnt increments by 1 only.
- FSM, 2 states:
  - IDLE:
    - if pending != 0, select the first set bit scanning ptr, ptr+1, ... mod 4;
    - register onehot_out = that bit and valid = 1;
    - go to PRESENT;
    - otherwise outputs stay 0.
  - PRESENT:
    - onehot_out and valid are held stable while ready=0 (no retraction, no re-arbitration, even if other bits become pending);
    - on valid & ready: clear that pending bit, set ptr = (granted index + 1) mod 4, drive valid=0 and onehot_out=0 next cycle, go to IDLE.
- Throughput: at most one grant per 2 clocks (mandatory idle cycle between grants).
- ready is ignored in IDLE.
- onehot_out is always registered. No combinational path from req_in or ready to any output.

Test Plan:
- Single request. rst pulse, then req_in=0100 held 5 cycles, ready=1. Expect:
  - pending=0100 at E2;
  - valid=1 and onehot_out=0100 at E3;
  - at E4, valid=0, onehot_out=0000, pending=0000;
  - no second grant although req_in stays high.
- Simultaneous all-four. req_in 0000->1111, ready=1. Expect:
  - grants 0001, 0010, 0100, 1000, each valid for exactly 1 cycle, with a 1-cycle gap between grants;
  - ptr wraps to 0;
  - drop_cnt=0.
- Round-robin order:
  - grant bit 1 first, so ptr=2;
  - then pulse req_in bits 0 and 3 together;
  - expect 1000 granted before 0001.
- Backpressure and drops:
  - req bit 0 granted with ready=0 for 10 cycles;
  - onehot_out=0001 and valid stay stable throughout;
  - re-pulse bit 0 three times during the stall, so drop_cnt=3;
  - raise ready, and bit 0 is granted exactly once.
- Coincident edge:
  - a new rise on bit 2 in the same cycle its handshake completes;
  - pending[2] stays 1, drop_cnt is unchanged, and bit 2 is granted again two cycles later.
- Reset mid-grant:
  - assert rst while valid=1 with req_in=0010 held;
  - outputs go to 0 immediately, asynchronously;
  - after release, 0010 is granted again SYNC_STAGES+1 edges later.
- Saturation: 300 drop events give drop_cnt=255.
